// File: rtl/pc_top.sv
// Program counter for the board datapath: load, PC-relative branch,
// sequential advance or hold, with the current PC shown on the LEDs.
module pc_top #(
    parameter int PC_WIDTH = 6,
    parameter int STEP     = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3:0]          buttons,
    input  logic [1:0]          switches,
    output logic [PC_WIDTH-1:0] leds
);

    localparam logic [PC_WIDTH-1:0] STEP_V = PC_WIDTH'(STEP);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_inc;
    logic [PC_WIDTH-1:0] w_off;
    logic [PC_WIDTH-1:0] w_branch;
    logic [PC_WIDTH-1:0] w_load;
    logic [PC_WIDTH-1:0] w_next;
    logic                w_ld;
    logic                w_br;
    logic                w_cnt;

    assign w_ld  = switches[0];
    assign w_br  = switches[1];
    assign w_cnt = buttons[2];

    // Offset is in words, zero-extended; all sums wrap modulo 2**PC_WIDTH.
    assign w_inc    = r_pc + STEP_V;
    assign w_off    = {{(PC_WIDTH-2){1'b0}}, buttons[1:0]} << 2;
    assign w_branch = w_inc + w_off;
    assign w_load   = {buttons[3], {(PC_WIDTH-1){1'b0}}};

    always_comb begin
        w_next = r_pc;
        if (w_ld) begin
            w_next = w_load;
        end else if (w_br) begin
            w_next = w_branch;
        end else if (w_cnt) begin
            w_next = w_inc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_next;
        end
    end

    assign leds = r_pc;

endmodule

// File: tb/tb_pc_top.sv
// Directed-vector bench for pc_top with immediate-assertion checks.
module tb_pc_top;

    logic       clock;
    logic       reset_n;
    logic [3:0] buttons;
    logic [1:0] switches;
    logic [5:0] leds;

    int vectors;
    int errors;

    pc_top #(
        .PC_WIDTH(6),
        .STEP(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .buttons (buttons),
        .switches(switches),
        .leds    (leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [5:0] exp);
        vectors++;
        assert (leds === exp) else begin
            errors++;
            $error("FAIL %s: leds=%0d expected=%0d", tag, leds, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic [1:0] sw, input logic [3:0] bt,
                        input string tag, input logic [5:0] exp);
        switches = sw;
        buttons  = bt;
        tick();
        check(tag, exp);
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        reset_n  = 1'b0;
        buttons  = 4'b0;
        switches = 2'b0;
        #1;
        check("reset_t0", 6'd0);
        for (int i = 0; i < 4; i++) begin
            buttons  = 4'($urandom_range(0, 15));
            switches = 2'($urandom_range(1, 3));
            tick();
            check("reset_held", 6'd0);
        end

        reset_n = 1'b1;
        step(2'b00, 4'b0000, "idle_0", 6'd0);
        step(2'b00, 4'b0000, "idle_1", 6'd0);

        step(2'b01, 4'b0000, "load0", 6'd0);
        step(2'b00, 4'b0100, "cnt4", 6'd4);
        step(2'b00, 4'b0100, "cnt8", 6'd8);
        step(2'b00, 4'b0100, "cnt12", 6'd12);

        step(2'b01, 4'b1000, "load32", 6'd32);
        step(2'b00, 4'b0100, "cnt36", 6'd36);
        step(2'b00, 4'b0100, "cnt40", 6'd40);
        step(2'b00, 4'b0100, "cnt44", 6'd44);
        step(2'b00, 4'b0000, "hold44a", 6'd44);
        step(2'b00, 4'b0000, "hold44b", 6'd44);

        step(2'b10, 4'b0011, "br44_off3", 6'd60);
        step(2'b00, 4'b0100, "wrap0", 6'd0);
        step(2'b00, 4'b0100, "cnt4b", 6'd4);
        step(2'b00, 4'b0100, "cnt8b", 6'd8);
        step(2'b10, 4'b0000, "br8_off0", 6'd12);
        step(2'b10, 4'b0010, "br12_off2", 6'd24);
        step(2'b01, 4'b0000, "load0b", 6'd0);
        step(2'b00, 4'b0100, "cnt4c", 6'd4);
        step(2'b10, 4'b0001, "br4_off1", 6'd12);
        step(2'b00, 4'b0100, "cnt16", 6'd16);
        step(2'b00, 4'b0100, "cnt20", 6'd20);

        step(2'b11, 4'b1111, "prio_load", 6'd32);
        step(2'b10, 4'b0101, "prio_br", 6'd40);

        step(2'b01, 4'b1000, "load32b", 6'd32);
        step(2'b00, 4'b0100, "cnt36b", 6'd36);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst", 6'd0);
        tick();
        check("rst_ignores_cnt", 6'd0);
        reset_n = 1'b1;
        step(2'b00, 4'b0100, "post_rst", 6'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
